// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between the FIFO front-end and the pointer controller.
// The front-end takes the master side and the controller takes the slave side.
interface fifo_ptr_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              clr;
    logic              wr_req;
    logic              rd_req;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              ovf;
    logic              udf;

    modport master (
        output clr, wr_req, rd_req,
        input  wr_en, rd_en, wr_ptr, rd_ptr, count,
        input  full, empty, almost_full, almost_empty, ovf, udf
    );

    modport slave (
        input  clr, wr_req, rd_req,
        output wr_en, rd_en, wr_ptr, rd_ptr, count,
        output full, empty, almost_full, almost_empty, ovf, udf
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer pair with a wrap bit for the synchronous FIFO; derives occupancy,
// full/empty, almost thresholds and sticky overflow/underflow flags.
module fifo_ptr_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input logic           ck,
    input logic           reset_n,
    fifo_ptr_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] AF_C = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C = AE_THRESH[ADDR_W:0];

    logic [ADDR_W:0] wp, rp;
    logic            ovf_q, udf_q;
    logic            full, empty;
    logic            wr_en, rd_en;
    logic [ADDR_W:0] count;

    // Extra MSB distinguishes full from empty when the address bits coincide.
    assign count = wp - rp;
    assign full  = (wp[ADDR_W] != rp[ADDR_W]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
    assign empty = (wp == rp);

    // reset_n gate keeps the write strobe quiet while reset is held.
    assign wr_en = bus.wr_req & ~full  & ~bus.clr & reset_n;
    assign rd_en = bus.rd_req & ~empty & ~bus.clr & reset_n;

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.clr) begin
            wp    <= '0;
            rp    <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp    <= wp + {{ADDR_W{1'b0}}, wr_en};
            rp    <= rp + {{ADDR_W{1'b0}}, rd_en};
            ovf_q <= ovf_q | (bus.wr_req & full);
            udf_q <= udf_q | (bus.rd_req & empty);
        end
    end

    assign bus.wr_en        = wr_en;
    assign bus.rd_en        = rd_en;
    assign bus.wr_ptr       = wp[ADDR_W-1:0];
    assign bus.rd_ptr       = rp[ADDR_W-1:0];
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_C);
    assign bus.almost_empty = (count <= AE_C);
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;
endmodule
